// File: rtl/div_row_issuer.sv
// div_row_issuer: captures one accumulator row plus its row-sum denominator,
// then streams numerator/denominator pairs to int_division one per handshake.
// Rows are fully buffered, so upstream is released at capture. A new row may
// load on the same edge as the last beat retires, leaving no bubble between rows.

// Per-element row storage: one numerator register, loaded when a row is captured.
module div_row_elem #(
  parameter int DATA_W = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Hold the numerator until the next row is captured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    q <= '0;
    else if (load) q <= d;
  end

endmodule

module div_row_issuer #(
  parameter int NUM_ELEMS = 16,
  parameter int DATA_W    = 18,
  parameter int IDX_W     = $clog2(NUM_ELEMS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        vld_in,
  output logic                        rdy_out,
  input  logic [NUM_ELEMS*DATA_W-1:0] num_row_in,
  input  logic [DATA_W-1:0]           den_in,
  output logic                        vld_out,
  input  logic                        rdy_in,
  output logic [DATA_W-1:0]           numerator_out,
  output logic [DATA_W-1:0]           denominator_out,
  output logic [IDX_W-1:0]            idx_out,
  output logic                        last_out,
  output logic                        busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  // Divider-side request bundle.
  typedef struct packed {
    logic [DATA_W-1:0] num;
    logic [DATA_W-1:0] den;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } req_t;

  state_t                             state;
  logic [IDX_W-1:0]                   idx_q;
  logic [DATA_W-1:0]                  den_q;
  logic [NUM_ELEMS-1:0][DATA_W-1:0]   row_in;
  logic [NUM_ELEMS-1:0][DATA_W-1:0]   row_q;
  logic                               issuing;
  logic                               on_last;
  logic                               accept;
  logic                               beat_done;
  req_t                               req;

  assign row_in    = num_row_in;
  assign issuing   = (state == ISSUE);
  assign on_last   = issuing && (idx_q == LAST_IDX);
  // Ready in IDLE, or when the final beat retires this cycle (back-to-back rows).
  assign rdy_out   = !issuing || (on_last && rdy_in);
  // rdy_out gates the capture, so vld_in/data are don't-care while it is low.
  assign accept    = vld_in && rdy_out;
  assign beat_done = issuing && rdy_in;

  // Row storage, one register per element.
  for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_elem
    div_row_elem #(.DATA_W(DATA_W)) u_elem (
      .clock (clock),
      .reset (reset),
      .load  (accept),
      .d     (row_in[k]),
      .q     (row_q[k])
    );
  end

  // Issue FSM: capture row, walk idx on each retired beat, reload or idle after the last.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx_q <= '0;
      den_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= ISSUE;
            idx_q <= '0;
            den_q <= den_in;
          end
        end
        ISSUE: begin
          if (beat_done) begin
            if (idx_q != LAST_IDX) begin
              idx_q <= idx_q + 1'b1;
            end else if (accept) begin
              idx_q <= '0;
              den_q <= den_in;
            end else begin
              state <= IDLE;
              idx_q <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx_q <= '0;
        end
      endcase
    end
  end

  // Output view is taken straight from registered state, so it is stable under backpressure.
  always_comb begin
    req      = '0;
    req.num  = row_q[idx_q];
    req.den  = den_q;
    req.idx  = idx_q;
    req.last = on_last;
  end

  assign vld_out         = issuing;
  assign busy            = issuing;
  assign numerator_out   = req.num;
  assign denominator_out = req.den;
  assign idx_out         = req.idx;
  assign last_out        = req.last;

endmodule

// File: tb/tb_div_row_issuer.sv
// Bench for div_row_issuer (NUM_ELEMS=4): directed row table, overlap/reset
// sequences and a randomized phase, all checked against a beat-queue model.
module tb_div_row_issuer;

  localparam int NE = 4;
  localparam int DW = 18;
  localparam int IW = 2;

  typedef logic [NE-1:0][DW-1:0] row_t;

  typedef struct {
    logic [DW-1:0] num;
    logic [DW-1:0] den;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  typedef struct {
    row_t          n;
    logic [DW-1:0] den;
    int            stall_idx;
    int            stall_cyc;
    int            exp_beats;
  } dir_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          vld_in = 1'b0;
  logic          rdy_out;
  row_t          num_row_in = '0;
  logic [DW-1:0] den_in = '0;
  logic          vld_out;
  logic          rdy_in = 1'b1;
  logic [DW-1:0] numerator_out;
  logic [DW-1:0] denominator_out;
  logic [IW-1:0] idx_out;
  logic          last_out;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int beat_cnt = 0;
  int vld_cyc = 0;
  beat_t expq[$];

  div_row_issuer #(.NUM_ELEMS(NE), .DATA_W(DW), .IDX_W(IW)) dut (
    .clock           (clock),
    .reset           (reset),
    .vld_in          (vld_in),
    .rdy_out         (rdy_out),
    .num_row_in      (num_row_in),
    .den_in          (den_in),
    .vld_out         (vld_out),
    .rdy_in          (rdy_in),
    .numerator_out   (numerator_out),
    .denominator_out (denominator_out),
    .idx_out         (idx_out),
    .last_out        (last_out),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic row_t mk(input int a, input int b, input int c, input int d);
    row_t r;
    r[0] = DW'(a); r[1] = DW'(b); r[2] = DW'(c); r[3] = DW'(d);
    return r;
  endfunction

  // Reference model: accepted rows expand into a queue of expected beats.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] p_num, p_den;
  logic [IW-1:0] p_idx;
  logic          p_last;
  always @(negedge clock) begin
    if (!reset) begin
      stall_prev <= 1'b0;
    end else begin
      automatic logic  exp_busy = (expq.size() > 0);
      automatic beat_t head = '{default: '0};
      if (exp_busy) head = expq[0];
      chk("vld_out", vld_out, exp_busy);
      chk("busy", busy, exp_busy);
      chk("rdy_out", rdy_out, !exp_busy || (head.last && rdy_in));
      if (exp_busy) begin
        chk("numerator_out", numerator_out, head.num);
        chk("denominator_out", denominator_out, head.den);
        chk("idx_out", idx_out, head.idx);
        chk("last_out", last_out, head.last);
        vld_cyc++;
      end else begin
        chk("last_out_idle", last_out, 1'b0);
      end
      if (stall_prev) begin
        chk("stall_vld", vld_out, 1'b1);
        chk("stall_num", numerator_out, p_num);
        chk("stall_den", denominator_out, p_den);
        chk("stall_idx", idx_out, p_idx);
        chk("stall_last", last_out, p_last);
      end
      stall_prev <= vld_out && !rdy_in;
      p_num <= numerator_out; p_den <= denominator_out;
      p_idx <= idx_out;       p_last <= last_out;
      if (exp_busy && rdy_in) begin
        void'(expq.pop_front());
        beat_cnt++;
      end
      if (vld_in && rdy_out) begin
        for (int k = 0; k < NE; k++)
          expq.push_back('{num: num_row_in[k], den: den_in, idx: IW'(k), last: (k == NE-1)});
      end
    end
  end

  task automatic wait_drain();
    int k;
    for (k = 0; k < 100; k++) begin
      @(posedge clock); #1;
      if (!vld_out) break;
    end
    chk("drain_timeout", (k < 100), 1);
    chk("queue_empty", expq.size(), 0);
  endtask

  task automatic present(input row_t n, input logic [DW-1:0] d);
    int k;
    num_row_in = n; den_in = d; vld_in = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rdy_out) break;
    end
    chk("accept_timeout", (k < 20), 1);
    @(posedge clock); #1;
    vld_in = 1'b0;
  endtask

  task automatic wait_idx(input int idx);
    int k;
    for (k = 0; k < 50; k++) begin
      if (vld_out && idx_out == IW'(idx)) break;
      @(posedge clock); #1;
    end
    chk("wait_idx_timeout", (k < 50), 1);
  endtask

  task automatic send_row(input row_t n, input logic [DW-1:0] d, input int sidx, input int scyc);
    @(posedge clock); #1;
    present(n, d);
    if (sidx >= 0) begin
      wait_idx(sidx);
      rdy_in = 1'b0;
      repeat (scyc) @(posedge clock);
      #1 rdy_in = 1'b1;
    end
    wait_drain();
  endtask

  // Second row B is offered while row A is at beat at_idx.
  task automatic overlap(input row_t a, input logic [DW-1:0] da,
                         input row_t b, input logic [DW-1:0] db, input int at_idx);
    int k;
    beat_cnt = 0; vld_cyc = 0;
    @(posedge clock); #1;
    present(a, da);
    wait_idx(at_idx);
    num_row_in = b; den_in = db; vld_in = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rdy_out) break;
    end
    chk("b_accept_timeout", (k < 20), 1);
    chk("b_on_last_beat", last_out, 1'b1);
    chk("b_on_last_idx", idx_out, NE-1);
    @(posedge clock); #1;
    vld_in = 1'b0;
    wait_drain();
    chk("overlap_beats", beat_cnt, 2*NE);
    chk("overlap_vld_cycles", vld_cyc, 2*NE);
  endtask

  initial begin
    dir_t tbl[3];
    tbl[0] = '{n: mk(128, 256, -64, 0),   den: DW'(512), stall_idx: -1, stall_cyc: 0, exp_beats: 4};
    tbl[1] = '{n: mk(128, 256, -64, 0),   den: DW'(512), stall_idx: 1,  stall_cyc: 3, exp_beats: 4};
    tbl[2] = '{n: mk(100, -100, 0, 255),  den: DW'(0),   stall_idx: -1, stall_cyc: 0, exp_beats: 4};

    // Reset state.
    #1;
    chk("rst_vld_out", vld_out, 0);
    chk("rst_rdy_out", rdy_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_last_out", last_out, 0);
    chk("rst_num", numerator_out, 0);
    chk("rst_den", denominator_out, 0);
    chk("rst_idx", idx_out, 0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;

    // Directed row table.
    for (int t = 0; t < 3; t++) begin
      beat_cnt = 0; vld_cyc = 0;
      send_row(tbl[t].n, tbl[t].den, tbl[t].stall_idx, tbl[t].stall_cyc);
      chk($sformatf("row%0d_beats", t), beat_cnt, tbl[t].exp_beats);
      chk($sformatf("row%0d_vld_cycles", t), vld_cyc, tbl[t].exp_beats + tbl[t].stall_cyc);
      #1 chk($sformatf("row%0d_rdy_after", t), rdy_out, 1);
    end

    // Back-to-back rows, B offered at A's last beat, then at A's beat 1.
    overlap(mk(1, 2, 3, 4), DW'(256), mk(5, 6, 7, 8), DW'(512), NE-1);
    overlap(mk(1, 2, 3, 4), DW'(256), mk(9, 10, 11, 12), DW'(768), 1);

    // Reset in the middle of a row.
    @(posedge clock); #1;
    present(mk(7, 7, 7, 7), DW'(100));
    wait_idx(2);
    reset = 1'b0;
    #1;
    chk("mid_rst_vld_out", vld_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_last", last_out, 0);
    chk("mid_rst_num", numerator_out, 0);
    chk("mid_rst_den", denominator_out, 0);
    chk("mid_rst_idx", idx_out, 0);
    chk("mid_rst_rdy", rdy_out, 1);
    expq.delete();
    @(posedge clock); #3 reset = 1'b1;
    beat_cnt = 0;
    send_row(mk(-256, 0, 0, 0), DW'(256), -1, 0);
    chk("post_rst_beats", beat_cnt, NE);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      @(posedge clock); #1;
      rdy_in = ($urandom_range(0, 3) != 0);
      vld_in = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < NE; k++) num_row_in[k] = DW'($urandom);
      den_in = DW'($urandom);
    end
    @(posedge clock); #1;
    vld_in = 1'b0; rdy_in = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_row_issuer.md
Name: div_row_issuer

Overview:
- Upstream feeder for int_division in the FlashAttention output-normalisation path.
- Accepts one finished output-accumulator row (NUM_ELEMS numerators) plus its softmax row-sum denominator in a single handshake.
- Registers the row, then issues one numerator/denominator pair per handshake to the divider, tagging each pair with its element index and a last flag.
- Fully buffered: upstream is released as soon as the row is captured.

Parameters:
- NUM_ELEMS, 16: elements per row (head dimension); must be ≥2.
- DATA_W, 18: width of one signed DIV_INPUT_QT value (Q9.8 plus sign); must equal $bits(DIV_INPUT_QT).
- IDX_W, $clog2(NUM_ELEMS): width of the element index.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- vld_in  input  1  upstream row valid.
- rdy_out  output  1  ready to accept a row from upstream.
- num_row_in  input  NUM_ELEMS*DATA_W  packed signed numerators; element k is bits [k*DATA_W +: DATA_W].
- den_in  input  DATA_W  signed row denominator.
- vld_out  output  1  divider request valid.
- rdy_in  input  1  divider ready.
- numerator_out  output  DATA_W  current element numerator.
- denominator_out  output  DATA_W  latched row denominator.
- idx_out  output  IDX_W  index of the current element.
- last_out  output  1  high when idx_out == NUM_ELEMS-1 and vld_out = 1.
- busy  output  1  high while a row is held (state ISSUE).

Behaviour:
- Reset (reset = 0, asynchronous):
  - State IDLE; idx = 0; row and denominator registers cleared to 0.
  - vld_out = 0, last_out = 0, busy = 0, numerator_out = denominator_out = 0, idx_out = 0, rdy_out = 1.
- Reset asserted mid-row:
  - The held row is discarded immediately; no further vld_out.
  - After release, the first vld_in is accepted as a fresh row.
- FSM has two states, IDLE and ISSUE.
- IDLE:
  - rdy_out = 1, vld_out = 0.
  - On vld_in & rdy_out: capture all NUM_ELEMS numerators and den_in, set idx = 0, go to ISSUE.
- ISSUE:
  - vld_out = 1.
  - numerator_out = row[idx], denominator_out = latched denominator, idx_out = idx.
  - On vld_out & rdy_in with idx < NUM_ELEMS-1: idx increments and the state stays ISSUE.
  - On vld_out & rdy_in with idx = NUM_ELEMS-1: go to IDLE.
- Handshake latency: a row accepted at edge N produces vld_out = 1 with idx 0 in the cycle after edge N.
  - One beat retires per cycle while rdy_in stays high, so NUM_ELEMS beats take NUM_ELEMS consecutive cycles.
- Back-to-back rows:
  - rdy_out = 1 in IDLE, and also in ISSUE when last_out & rdy_in (combinational from rdy_in).
  - If a new row is accepted on the same edge as the last beat retires: reload registers, idx = 0, stay in ISSUE. No bubble between rows.
- Backpressure: while vld_out & !rdy_in, numerator_out, denominator_out, idx_out and last_out stay stable. vld_out never deasserts before its handshake completes.
- While busy and not on the last beat, rdy_out = 0. vld_in and the input data are ignored; the registered row is not overwritten.
- Arithmetic: no arithmetic on data. Values pass bit-exact, sign preserved.
- Zero denominator: den_in = 0 is forwarded unchanged; int_division's saturation handles it.
- vld_in with X data while rdy_out = 0 must not corrupt state. Outputs carry no X after reset.

Test Plan:
- Bench uses NUM_ELEMS=4, DATA_W=18. Row {128, 256, -64, 0} (0.5, 1.0, -0.25, 0.0 in Q9.8), den 512 (2.0), rdy_in = 1 → 4 consecutive beats:
  - idx 0..3, numerator_out 128, 256, -64, 0, denominator_out 512 every beat.
  - last_out only on idx 3.
  - Chained int_division returns 32, 64, -16, 0 (Q0.7).
  - rdy_out returns to 1 the cycle after the last beat.
- Same row, rdy_in held low for 3 cycles at idx 1 → numerator_out stays 256 and idx_out stays 1 for all 3 cycles; beat count stays 4; no element duplicated or skipped.
- Row A {1,2,3,4}/256, then row B {5,6,7,8}/512 presented with vld_in = 1 during A's last beat, rdy_in = 1 → B accepted on that edge; 8 beats in 8 consecutive cycles; numerators 1..8; denominator switches 256→512 exactly at B's idx 0.
- During row A's beat idx 1, drive vld_in = 1 with a different row → rdy_out = 0; remaining A beats unchanged; the second row is accepted only at A's last beat.
- Assert reset low at idx 2 of a row → vld_out drops to 0 immediately and all outputs go to 0. After release, a new row {-256,0,0,0}/256 issues from idx 0 with numerator_out = -256.
- Row {100, -100, 0, 255}, den 0 → 4 beats with denominator_out = 0 and numerators forwarded unchanged; no hang.
